// File: rtl/lsu_bus_arbiter_if.sv
// rtl/lsu_bus_arbiter_if.sv - LSU request/response channel bundle
//
// One LSU channel: a request half (vld/rdy plus wen, rwtyp, addr, wdata)
// and a response half (vld/rdy plus rdata, err).
//   master : the side that issues requests and consumes responses
//   slave  : the side that accepts requests and returns responses
// The downstream AHB-lite side never reports an error, so rsp_err is only
// visible through the slave modport.
interface lsu_bus_arbiter_if;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wen;
  logic [2:0]  req_rwtyp;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_vld, req_wen, req_rwtyp, req_addr, req_wdata, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wen, req_rwtyp, req_addr, req_wdata, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_bus_arbiter.sv
// rtl/lsu_bus_arbiter.sv - two-master round-robin LSU channel arbiter with timeout
//
// Shares one LSU channel into the AHB-lite master between the core LSU (m0)
// and the UART debug/loader (m1). One transaction in flight at a time.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   m0, m1     : upstream masters (slave modport of lsu_bus_arbiter_if)
//   s          : downstream channel (master modport of lsu_bus_arbiter_if)
//   arb_busy   : high whenever the arbiter is not idle
//   arb_owner  : index of the currently or most recently granted master
// Parameters:
//   TIMEOUT_CYCLES : response wait limit after the request handshake (2..65535)
//   ERR_RDATA      : read data returned on a timeout abort
module lsu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  lsu_bus_arbiter_if.slave        m0,
  lsu_bus_arbiter_if.slave        m1,
  lsu_bus_arbiter_if.master       s,
  output logic                    arb_busy,
  output logic                    arb_owner
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic        rr_ptr;
  logic [15:0] to_cnt;

  logic        own_req_vld;
  logic        own_rsp_rdy;
  logic        req_rdy_c;
  logic        rsp_vld_c;
  logic [31:0] rsp_rdata_c;
  logic        rsp_err_c;

  assign own_req_vld = arb_owner ? m1.req_vld : m0.req_vld;
  assign own_rsp_rdy = arb_owner ? m1.rsp_rdy : m0.rsp_rdy;

  // Downstream request fields always follow the registered owner.
  assign s.req_wen   = arb_owner ? m1.req_wen   : m0.req_wen;
  assign s.req_rwtyp = arb_owner ? m1.req_rwtyp : m0.req_rwtyp;
  assign s.req_addr  = arb_owner ? m1.req_addr  : m0.req_addr;
  assign s.req_wdata = arb_owner ? m1.req_wdata : m0.req_wdata;

  assign arb_busy = (state != ST_IDLE);

  always_comb begin
    s.req_vld   = 1'b0;
    s.rsp_rdy   = 1'b0;
    req_rdy_c   = 1'b0;
    rsp_vld_c   = 1'b0;
    rsp_rdata_c = 32'h0;
    rsp_err_c   = 1'b0;
    case (state)
      ST_REQ: begin
        // Dropping req_vld early withdraws the downstream request too.
        s.req_vld = own_req_vld;
        req_rdy_c = s.req_rdy;
      end
      ST_RSP: begin
        s.rsp_rdy   = own_rsp_rdy;
        rsp_vld_c   = s.rsp_vld;
        rsp_rdata_c = s.rsp_rdata;
      end
      ST_ERR: begin
        // Always ready downstream so a late response is drained and dropped.
        s.rsp_rdy   = 1'b1;
        rsp_vld_c   = 1'b1;
        rsp_rdata_c = ERR_RDATA;
        rsp_err_c   = 1'b1;
      end
      default: begin
        s.req_vld = 1'b0;
      end
    endcase
  end

  // The non-owner sees nothing but zeros.
  assign m0.req_rdy   = ~arb_owner & req_rdy_c;
  assign m1.req_rdy   =  arb_owner & req_rdy_c;
  assign m0.rsp_vld   = ~arb_owner & rsp_vld_c;
  assign m1.rsp_vld   =  arb_owner & rsp_vld_c;
  assign m0.rsp_rdata = arb_owner ? 32'h0 : rsp_rdata_c;
  assign m1.rsp_rdata = arb_owner ? rsp_rdata_c : 32'h0;
  assign m0.rsp_err   = ~arb_owner & rsp_err_c;
  assign m1.rsp_err   =  arb_owner & rsp_err_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      arb_owner <= 1'b0;
      rr_ptr    <= 1'b0;
      to_cnt    <= 16'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0.req_vld || m1.req_vld) begin
            // Contention resolves to rr_ptr; otherwise the lone requester wins.
            arb_owner <= (m0.req_vld && m1.req_vld) ? rr_ptr : m1.req_vld;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!own_req_vld) begin
            state <= ST_IDLE;
          end else if (s.req_rdy) begin
            state  <= ST_RSP;
            to_cnt <= 16'h0;
            rr_ptr <= ~arb_owner;
          end
        end
        ST_RSP: begin
          // A response present in the limit cycle beats the timeout, and the
          // counter holds while a response is waiting on the master.
          if (s.rsp_vld) begin
            if (own_rsp_rdy) begin
              state <= ST_IDLE;
            end
          end else if (to_cnt == CNT_LAST) begin
            state <= ST_ERR;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        ST_ERR: begin
          if (own_rsp_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb/tb_lsu_bus_arbiter.sv - self-checking bench for lsu_bus_arbiter
module tb_lsu_bus_arbiter;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int          K    = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic arb_busy;
  logic arb_owner;

  lsu_bus_arbiter_if m0_if ();
  lsu_bus_arbiter_if m1_if ();
  lsu_bus_arbiter_if s_if ();

  lsu_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .arb_busy  (arb_busy),
    .arb_owner (arb_owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Random-phase transaction tables and reference model state.
  logic [31:0] ra [2][K];
  logic [31:0] rd [2][K];
  logic        rw [2][K];
  logic [2:0]  rt [2][K];
  int          exp_m [$];
  int          exp_i [$];
  int          idx [2];
  bit          waiting [2];
  int          rsp_done [2];
  bit          sl_busy, sl_silent;
  int          sl_cnt, sl_delay;
  logic [31:0] sl_data;
  int          cur_m;
  logic [31:0] cur_rdata;
  logic        cur_err;
  int          em, ei, cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero();
    m0_if.req_vld = 0; m0_if.req_wen = 0; m0_if.req_rwtyp = 0; m0_if.req_addr = 0;
    m0_if.req_wdata = 0; m0_if.rsp_rdy = 0;
    m1_if.req_vld = 0; m1_if.req_wen = 0; m1_if.req_rwtyp = 0; m1_if.req_addr = 0;
    m1_if.req_wdata = 0; m1_if.rsp_rdy = 0;
    s_if.req_rdy = 0; s_if.rsp_vld = 0; s_if.rsp_rdata = 0;
  endtask

  task automatic quiet(input string tag);
    check({tag, "_ctl"}, 32'({arb_busy, m0_if.req_rdy, m1_if.req_rdy, m0_if.rsp_vld, m1_if.rsp_vld,
                              s_if.req_vld, s_if.rsp_rdy, m0_if.rsp_err, m1_if.rsp_err}), 32'h0);
    check({tag, "_rdata"}, m0_if.rsp_rdata | m1_if.rsp_rdata, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_zero();
    rstn = 1'b0;
    repeat (2) tick();
    quiet("rst");
    check("rst_owner", 32'(arb_owner), 32'h0);
    rstn = 1'b1;
    tick();

    // Single read from m0, response two cycles after the handshake.
    m0_if.req_vld = 1; m0_if.req_wen = 0; m0_if.req_rwtyp = 3'd2;
    m0_if.req_addr = 32'h1000_0004; s_if.req_rdy = 1;
    #1;
    check("t1_no_fwd_in_idle", 32'(s_if.req_vld), 32'h0);
    tick();
    check("t1_s_req_vld", 32'(s_if.req_vld), 32'h1);
    check("t1_s_addr", s_if.req_addr, 32'h1000_0004);
    check("t1_s_ctl", 32'({s_if.req_wen, s_if.req_rwtyp}), 32'h2);
    check("t1_m0_req_rdy", 32'(m0_if.req_rdy), 32'h1);
    check("t1_m1_quiet", 32'({m1_if.req_rdy, m1_if.rsp_vld}), 32'h0);
    tick();
    m0_if.req_vld = 0; s_if.req_rdy = 0; m0_if.rsp_rdy = 1;
    repeat (2) tick();
    s_if.rsp_vld = 1; s_if.rsp_rdata = 32'h1234_5678;
    #1;
    check("t1_rsp_vld", 32'(m0_if.rsp_vld), 32'h1);
    check("t1_rsp_rdata", m0_if.rsp_rdata, 32'h1234_5678);
    check("t1_rsp_err", 32'(m0_if.rsp_err), 32'h0);
    check("t1_s_rsp_rdy", 32'(s_if.rsp_rdy), 32'h1);
    check("t1_m1_rsp_quiet", 32'({m1_if.rsp_vld, m1_if.rsp_rdata}), 32'h0);
    tick();
    s_if.rsp_vld = 0;
    #1;
    quiet("t1_end");

    // Downstream backpressure on a write.
    m0_if.req_vld = 1; m0_if.req_wen = 1; m0_if.req_rwtyp = 3'd5;
    m0_if.req_addr = 32'h2000_0010; m0_if.req_wdata = 32'hCAFE_0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_vld", 32'(s_if.req_vld), 32'h1);
      check("t2_hold_addr", s_if.req_addr, 32'h2000_0010);
      check("t2_hold_wdata", s_if.req_wdata, 32'hCAFE_0001);
      check("t2_hold_ctl", 32'({s_if.req_wen, s_if.req_rwtyp}), 32'hD);
      check("t2_m0_rdy_low", 32'(m0_if.req_rdy), 32'h0);
      tick();
    end
    s_if.req_rdy = 1;
    #1;
    check("t2_m0_rdy_follows", 32'(m0_if.req_rdy), 32'h1);
    tick();
    m0_if.req_vld = 0; m0_if.req_wen = 0; s_if.req_rdy = 0;
    s_if.rsp_vld = 1; s_if.rsp_rdata = 32'h0;
    #1;
    check("t2_rsp_vld", 32'(m0_if.rsp_vld), 32'h1);
    tick();
    s_if.rsp_vld = 0;

    // Timeout on m1 with TIMEOUT_CYCLES = 8.
    m1_if.req_vld = 1; m1_if.req_addr = 32'h3000_0000; m1_if.req_rwtyp = 3'd2;
    tick();
    s_if.req_rdy = 1;
    #1;
    check("t3_owner", 32'(arb_owner), 32'h1);
    tick();
    m1_if.req_vld = 0; s_if.req_rdy = 0; m1_if.rsp_rdy = 0;
    check("t3_wait_0", 32'(m1_if.rsp_vld), 32'h0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("t3_wait", 32'(m1_if.rsp_vld), 32'h0);
    end
    tick();
    check("t3_err_vld", 32'(m1_if.rsp_vld), 32'h1);
    check("t3_err_rdata", m1_if.rsp_rdata, ERRD);
    check("t3_err_flag", 32'(m1_if.rsp_err), 32'h1);
    check("t3_m0_quiet", 32'({m0_if.rsp_vld, m0_if.rsp_err}), 32'h0);
    tick();
    check("t3_err_hold", 32'(m1_if.rsp_vld), 32'h1);
    s_if.rsp_vld = 1; s_if.rsp_rdata = 32'h5555_5555;
    #1;
    check("t3_late_drain_rdy", 32'(s_if.rsp_rdy), 32'h1);
    check("t3_late_not_fwd", m1_if.rsp_rdata, ERRD);
    tick();
    s_if.rsp_vld = 0; m1_if.rsp_rdy = 1;
    tick();
    m1_if.rsp_rdy = 0;
    #1;
    quiet("t3_end");

    // Response backpressure; the response arrives in the limit cycle.
    m0_if.req_vld = 1; m0_if.req_addr = 32'h4000_0008;
    tick();
    s_if.req_rdy = 1;
    tick();
    m0_if.req_vld = 0; s_if.req_rdy = 0; m0_if.rsp_rdy = 0;
    repeat (7) tick();
    s_if.rsp_vld = 1; s_if.rsp_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_bp_s_rdy", 32'(s_if.rsp_rdy), 32'h0);
      check("t4_bp_vld", 32'(m0_if.rsp_vld), 32'h1);
      check("t4_bp_rdata", m0_if.rsp_rdata, 32'h0BAD_F00D);
      tick();
    end
    m0_if.rsp_rdy = 1;
    #1;
    check("t4_s_rdy", 32'(s_if.rsp_rdy), 32'h1);
    check("t4_no_timeout", 32'({m0_if.rsp_err, m0_if.rsp_rdata}), 33'h0_0BAD_F00D);
    tick();
    s_if.rsp_vld = 0; m0_if.rsp_rdy = 0;
    #1;
    quiet("t4_single_rsp");

    // Reset while in RSP; rr_ptr points at m1 before reset.
    m0_if.req_vld = 1; m0_if.req_addr = 32'h5000_0000;
    tick();
    s_if.req_rdy = 1;
    tick();
    m0_if.req_vld = 0; s_if.req_rdy = 0;
    s_if.rsp_vld = 1; s_if.rsp_rdata = 32'h77;
    #1;
    check("t5_pre_rst_vld", 32'(m0_if.rsp_vld), 32'h1);
    rstn = 1'b0;
    #1;
    quiet("t5_async_rst");
    s_if.rsp_vld = 0;
    tick();
    rstn = 1'b1;
    m0_if.req_vld = 1; m0_if.req_addr = 32'h6000_0000;
    m1_if.req_vld = 1; m1_if.req_addr = 32'h6100_0000;
    tick();
    check("t5_grant_m0", 32'(arb_owner), 32'h0);
    check("t5_addr_m0", s_if.req_addr, 32'h6000_0000);
    rstn = 1'b0;
    drive_zero();
    tick();
    rstn = 1'b1;
    tick();

    // Randomised phase: both masters keep K requests each pending.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < K; i++) begin
        ra[m][i] = {$urandom_range(0, 65535), 14'(i), 2'(m)} ;
        rd[m][i] = $urandom;
        rw[m][i] = 1'($urandom_range(0, 1));
        rt[m][i] = 3'($urandom_range(0, 7));
      end
    end
    for (int i = 0; i < K; i++) begin
      exp_m.push_back(0); exp_i.push_back(i);
      exp_m.push_back(1); exp_i.push_back(i);
    end
    idx[0] = 0; idx[1] = 0; waiting[0] = 0; waiting[1] = 0;
    rsp_done[0] = 0; rsp_done[1] = 0;
    sl_busy = 0; sl_silent = 0; sl_cnt = 0; sl_delay = 0; sl_data = 0;
    cur_m = 0; cur_rdata = 0; cur_err = 0; cycles = 0;

    while ((rsp_done[0] < K || rsp_done[1] < K) && cycles < 3000) begin
      m0_if.req_vld = !waiting[0] && idx[0] < K;
      if (idx[0] < K) begin
        m0_if.req_addr = ra[0][idx[0]]; m0_if.req_wdata = rd[0][idx[0]];
        m0_if.req_wen = rw[0][idx[0]]; m0_if.req_rwtyp = rt[0][idx[0]];
      end
      m1_if.req_vld = !waiting[1] && idx[1] < K;
      if (idx[1] < K) begin
        m1_if.req_addr = ra[1][idx[1]]; m1_if.req_wdata = rd[1][idx[1]];
        m1_if.req_wen = rw[1][idx[1]]; m1_if.req_rwtyp = rt[1][idx[1]];
      end
      s_if.req_rdy  = ($urandom_range(0, 2) != 0);
      m0_if.rsp_rdy = ($urandom_range(0, 3) != 0);
      m1_if.rsp_rdy = ($urandom_range(0, 3) != 0);
      s_if.rsp_vld   = sl_busy && !sl_silent && (sl_cnt >= sl_delay);
      s_if.rsp_rdata = sl_data;
      #1;
      check("rnd_exclusive", 32'((m0_if.rsp_vld & m1_if.rsp_vld) | (m0_if.req_rdy & m1_if.req_rdy)), 32'h0);
      if (s_if.req_vld && s_if.req_rdy) begin
        if (exp_m.size() == 0) begin
          check("rnd_extra_req", 32'h1, 32'(exp_m.size()));
        end else begin
          em = exp_m.pop_front();
          ei = exp_i.pop_front();
          check("rnd_owner", 32'(arb_owner), 32'(em));
          check("rnd_addr", s_if.req_addr, ra[em][ei]);
          check("rnd_wdata", s_if.req_wdata, rd[em][ei]);
          check("rnd_ctl", 32'({s_if.req_wen, s_if.req_rwtyp}), 32'({rw[em][ei], rt[em][ei]}));
          sl_busy   = 1;
          sl_cnt    = 0;
          sl_silent = ($urandom_range(0, 4) == 0);
          sl_delay  = $urandom_range(0, 4);
          sl_data   = ra[em][ei] ^ 32'h5A5A_0000;
          cur_m     = em;
          cur_err   = sl_silent;
          cur_rdata = sl_silent ? ERRD : sl_data;
        end
      end
      if (m0_if.req_vld && m0_if.req_rdy) begin waiting[0] = 1; idx[0]++; end
      if (m1_if.req_vld && m1_if.req_rdy) begin waiting[1] = 1; idx[1]++; end
      if (s_if.rsp_vld && s_if.rsp_rdy) sl_busy = 0;
      else if (sl_busy) sl_cnt++;
      if (m0_if.rsp_vld && m0_if.rsp_rdy) begin
        check("rnd_rsp_to_m0", 32'(cur_m), 32'h0);
        check("rnd_rsp_rdata", m0_if.rsp_rdata, cur_rdata);
        check("rnd_rsp_err", 32'(m0_if.rsp_err), 32'(cur_err));
        waiting[0] = 0; rsp_done[0]++; sl_busy = 0;
      end
      if (m1_if.rsp_vld && m1_if.rsp_rdy) begin
        check("rnd_rsp_to_m1", 32'(cur_m), 32'h1);
        check("rnd_rsp_rdata", m1_if.rsp_rdata, cur_rdata);
        check("rnd_rsp_err", 32'(m1_if.rsp_err), 32'(cur_err));
        waiting[1] = 0; rsp_done[1]++; sl_busy = 0;
      end
      tick();
      cycles++;
    end
    check("rnd_completed_in_budget", 32'(cycles < 3000), 32'h1);
    check("rnd_all_forwarded", 32'(exp_m.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lsu_bus_arbiter.md
Name: lsu_bus_arbiter

Overview:
- Two-master arbiter sharing the single LSU request/response channel into the AHB-lite master between the core LSU (master 0) and the UART debug/loader master (master 1).
- Sits between core_top/debug loader and ahb_lite_top.
- Allows exactly one outstanding transaction.
- Uses round-robin grant.
- Aborts with an error response if the bus does not answer within a timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for s_rsp_vld after the request handshake before aborting. Legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on a timeout abort.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- mN_req_vld  in  1  master N request valid (N = 0, 1).
- mN_req_rdy  out  1  master N request accepted.
- mN_req_wen  in  1  1 = write, 0 = read.
- mN_req_rwtyp  in  3  access size/sign type, passed through unchanged.
- mN_req_addr  in  32  byte address.
- mN_req_wdata  in  32  write data.
- mN_rsp_vld  out  1  response valid to master N.
- mN_rsp_rdy  in  1  master N accepts response.
- mN_rsp_rdata  out  32  read data.
- mN_rsp_err  out  1  response is a timeout abort.
- s_req_vld  out  1  downstream request valid.
- s_req_rdy  in  1  downstream accepts request.
- s_req_wen, s_req_rwtyp[3], s_req_addr[32], s_req_wdata[32]  out  downstream request fields.
- s_rsp_vld  in  1  downstream response valid.
- s_rsp_rdy  out  1  arbiter accepts downstream response.
- s_rsp_rdata  in  32  downstream read data.
- arb_busy  out  1  high in any state other than IDLE.
- arb_owner  out  1  currently or last granted master index.

Behaviour:
- Reset values:
  - State = IDLE, arb_owner = 0, rr_ptr = 0 (master 0 preferred), timeout counter = 0.
  - All vld/rdy outputs = 0; all rdata/err outputs = 0.
- Only mN_req_rdy, s_req_vld, s_rsp_rdy and mN_rsp_vld have combinational dependence on state and inputs; grant is registered.
- State IDLE:
  - Samples both mN_req_vld.
  - If only one is high, grant it.
  - If both are high, grant master rr_ptr.
  - On grant: register arb_owner, go to REQ. No request is forwarded in IDLE.
  - All rdy outputs = 0.
- State REQ:
  - s_req_vld = 1; s_req_* fields are muxed combinationally from master arb_owner.
  - m[arb_owner]_req_rdy = s_req_rdy; the other master's rdy = 0.
  - On s_req_vld & s_req_rdy: go to RSP, clear counter, set rr_ptr = ~arb_owner.
  - If the owner drops req_vld before the handshake (protocol violation), return to IDLE without forwarding further. This is the only case where s_req_vld deasserts before handshake.
- State RSP:
  - s_rsp_rdy = m[arb_owner]_rsp_rdy.
  - m[arb_owner]_rsp_vld = s_rsp_vld, rdata = s_rsp_rdata, err = 0.
  - On s_rsp_vld & s_rsp_rdy: go to IDLE.
  - Otherwise the counter increments while s_rsp_vld = 0. When it reaches TIMEOUT_CYCLES-1 with no s_rsp_vld, go to ERR.
  - If s_rsp_vld arrives in the same cycle the counter hits its limit, the response wins.
- State ERR:
  - m[arb_owner]_rsp_vld = 1, rdata = ERR_RDATA, err = 1.
  - s_rsp_rdy = 1, so any late downstream response is drained and discarded.
  - Go to IDLE on m[arb_owner]_rsp_rdy.
- Minimum latency, request vld to downstream vld: 1 cycle (IDLE to REQ).
- Back-to-back: after returning to IDLE, a new grant is made on the next cycle. Throughput is at most one transaction per 3 cycles.
- Fairness: with both masters continuously requesting, grants alternate 0, 1, 0, 1.
- Non-owner master: rsp_vld = 0 and req_rdy = 0 at all times.
- Reset asserted mid-transaction:
  - Immediately returns all outputs to reset values.
  - The in-flight downstream transaction is abandoned; downstream must also be reset by the same rstn.

Test Plan:
- Single read, master 0 only:
  - Stimulus: m0 read addr 0x1000_0004; s_req_rdy = 1; s_rsp_vld 2 cycles later with 0x1234_5678.
  - Response: s_req_vld exactly 1 cycle after m0_req_vld; m0_rsp_rdata = 0x1234_5678, err = 0; m1 outputs stay 0.
- Simultaneous requests, both held for 4 transactions each:
  - Response: grant order m0, m1, m0, m1; s_req_addr alternates accordingly; no request is lost.
- Downstream backpressure:
  - Stimulus: s_req_rdy low for 5 cycles.
  - Response: s_req_vld and all fields stable for 5 cycles; m0_req_rdy rises in the same cycle as s_req_rdy.
- Timeout, TIMEOUT_CYCLES = 8, no s_rsp_vld:
  - Response: 8 cycles after the request handshake, m1_rsp_vld = 1, rdata = 0xDEAD_BEEF, err = 1.
  - A late s_rsp_vld in ERR is accepted (s_rsp_rdy = 1) and not forwarded.
- Response backpressure:
  - Stimulus: m0_rsp_rdy low for 3 cycles during s_rsp_vld.
  - Response: s_rsp_rdy low for those 3 cycles; single response delivered; timeout counter does not advance while s_rsp_vld is high.
- Reset mid-RSP:
  - Stimulus: rstn pulsed low while in RSP.
  - Response: arb_busy = 0 and all vld = 0 asynchronously; the next request is granted to m0 (rr_ptr reset).
